// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
//   Shared definitions for the SPI mode-0 master:
//     - FSM state encoding (IDLE/SETUP/SHIFT/HOLD/GAP)
//     - SPI mode constant (CPOL=0, CPHA=0)
//     - small constant functions used to size counters from parameters
// -----------------------------------------------------------------------------
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    // {CPOL, CPHA}; this master only implements mode 0.
    localparam logic [1:0] SPI_MODE_0 = 2'b00;

    // Width needed to count 0 .. n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_clk_div.sv
// -----------------------------------------------------------------------------
// spi_master_clk_div
//   SCLK half-period timer. While en_i is high it counts clk_i cycles and
//   raises tick_o on the last cycle of each CLK_DIV-cycle half period, then
//   reloads. clear_i forces the count back to the start of a half period so
//   every SHIFT phase begins with a full-length first half.
// Ports:
//   clk_i    in   system clock
//   rst_n_i  in   asynchronous active-low reset
//   en_i     in   count enable
//   clear_i  in   restart the half period (has priority over en_i)
//   tick_o   out  high on the final cycle of a half period (combinational)
// -----------------------------------------------------------------------------
module spi_master_clk_div
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_reg;

    assign tick_o = en_i && (div_cnt_reg == DIV_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_reg <= '0;
        end else if (clear_i) begin
            div_cnt_reg <= '0;
        end else if (en_i) begin
            if (tick_o) div_cnt_reg <= '0;
            else        div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-0 master (CPOL=0, CPHA=0), MSB first, fixed FRAME_W-bit frames.
//   One frame is exchanged per accepted tx word; the word received during
//   that frame is returned on rx_data_o with a one-cycle rx_valid_o pulse.
//   Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//   Accept edge to CS rise = CS_SETUP + 2*CLK_DIV*FRAME_W + CS_HOLD cycles.
// Ports:
//   clk_i       in   system clock
//   rst_n_i     in   asynchronous active-low reset
//   tx_valid_i  in   tx word offered
//   tx_ready_o  out  master can accept a word (IDLE)
//   tx_data_i   in   word to shift out
//   abort_i     in   terminate the current frame
//   rx_valid_o  out  one-cycle pulse, rx_data_o valid
//   rx_data_o   out  last completed received frame
//   aborted_o   out  one-cycle pulse, frame was aborted
//   busy_o      out  state != IDLE
//   spi_sclk_o  out  SPI clock, idles low
//   spi_cs_o    out  chip select, active low
//   spi_mosi_o  out  master out
//   spi_miso_i  in   master in (already synchronised externally)
// -----------------------------------------------------------------------------
module spi_master
    import spi_master_pkg::*;
#(
    parameter int FRAME_W  = 32,
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    input  logic [FRAME_W-1:0] tx_data_i,
    input  logic               abort_i,
    output logic               rx_valid_o,
    output logic [FRAME_W-1:0] rx_data_o,
    output logic               aborted_o,
    output logic               busy_o,
    output logic               spi_sclk_o,
    output logic               spi_cs_o,
    output logic               spi_mosi_o,
    input  logic               spi_miso_i
);

    localparam int PH_W  = cnt_width(max3(CS_SETUP, CS_HOLD, CS_IDLE));
    localparam int BIT_W = cnt_width(FRAME_W);

    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
    // The first IDLE cycle is itself a CS-high cycle, so GAP lasts
    // CS_IDLE-1 cycles and is skipped entirely when CS_IDLE is 1. This keeps
    // CS high for exactly CS_IDLE cycles on back-to-back frames.
    localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'((CS_IDLE > 1) ? CS_IDLE - 2 : 0);
    localparam spi_state_t       AFTER_CS   = (CS_IDLE > 1) ? ST_GAP : ST_IDLE;
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);

    spi_state_t         state_reg,     state_next;
    logic [PH_W-1:0]    phase_cnt_reg, phase_cnt_next;
    logic [BIT_W-1:0]   bit_cnt_reg,   bit_cnt_next;
    logic [FRAME_W-1:0] tx_shift_reg,  tx_shift_next;
    logic [FRAME_W-1:0] rx_shift_reg,  rx_shift_next;
    logic [FRAME_W-1:0] rx_data_reg,   rx_data_next;
    logic               sclk_reg,      sclk_next;
    logic               cs_reg,        cs_next;
    logic               mosi_reg,      mosi_next;
    logic               rx_valid_reg,  rx_valid_next;
    logic               aborted_reg,   aborted_next;

    logic               half_tick;
    logic               in_frame;

    // The divider only runs during SHIFT and is held cleared otherwise, so the
    // first low half of bit 0 always lasts the full CLK_DIV cycles.
    spi_master_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_reg == ST_SHIFT),
        .clear_i (state_reg != ST_SHIFT),
        .tick_o  (half_tick)
    );

    assign in_frame = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) ||
                      (state_reg == ST_HOLD);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            phase_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            rx_data_reg   <= '0;
            sclk_reg      <= 1'b0;
            cs_reg        <= 1'b1;
            mosi_reg      <= 1'b0;
            rx_valid_reg  <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            tx_shift_reg  <= tx_shift_next;
            rx_shift_reg  <= rx_shift_next;
            rx_data_reg   <= rx_data_next;
            sclk_reg      <= sclk_next;
            cs_reg        <= cs_next;
            mosi_reg      <= mosi_next;
            rx_valid_reg  <= rx_valid_next;
            aborted_reg   <= aborted_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        tx_shift_next  = tx_shift_reg;
        rx_shift_next  = rx_shift_reg;
        rx_data_next   = rx_data_reg;
        sclk_next      = sclk_reg;
        cs_next        = cs_reg;
        mosi_next      = mosi_reg;
        rx_valid_next  = 1'b0;
        aborted_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (tx_valid_i) begin
                    state_next     = ST_SETUP;
                    phase_cnt_next = '0;
                    bit_cnt_next   = '0;
                    cs_next        = 1'b0;
                    tx_shift_next  = tx_data_i;
                    rx_shift_next  = '0;
                    mosi_next      = tx_data_i[FRAME_W-1];
                end
            end

            ST_SETUP: begin
                if (phase_cnt_reg == SETUP_LAST) begin
                    state_next     = ST_SHIFT;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 1'b1;
                end
            end

            ST_SHIFT: begin
                if (half_tick) begin
                    if (!sclk_reg) begin
                        // Rising edge: sample MISO into the receive register.
                        sclk_next     = 1'b1;
                        rx_shift_next = {rx_shift_reg[FRAME_W-2:0], spi_miso_i};
                    end else begin
                        sclk_next = 1'b0;
                        if (bit_cnt_reg == BIT_LAST) begin
                            // MOSI keeps the last bit through HOLD.
                            state_next     = ST_HOLD;
                            phase_cnt_next = '0;
                        end else begin
                            // Falling edge: present the next bit. The transmit
                            // register rotates so its MSB always holds the bit
                            // currently on MOSI.
                            bit_cnt_next  = bit_cnt_reg + 1'b1;
                            tx_shift_next = {tx_shift_reg[FRAME_W-2:0],
                                             tx_shift_reg[FRAME_W-1]};
                            mosi_next     = tx_shift_reg[FRAME_W-2];
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (phase_cnt_reg == HOLD_LAST) begin
                    state_next     = AFTER_CS;
                    phase_cnt_next = '0;
                    cs_next        = 1'b1;
                    mosi_next      = 1'b0;
                    rx_data_next   = rx_shift_reg;
                    rx_valid_next  = 1'b1;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 1'b1;
                end
            end

            ST_GAP: begin
                if (phase_cnt_reg == GAP_LAST) begin
                    state_next     = ST_IDLE;
                    phase_cnt_next = '0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next     = ST_IDLE;
                phase_cnt_next = '0;
                sclk_next      = 1'b0;
                cs_next        = 1'b1;
                mosi_next      = 1'b0;
            end
        endcase

        // Abort overrides everything above, including a completion that
        // would otherwise land on this same edge.
        if (abort_i && in_frame) begin
            state_next     = AFTER_CS;
            phase_cnt_next = '0;
            sclk_next      = 1'b0;
            cs_next        = 1'b1;
            mosi_next      = 1'b0;
            rx_data_next   = rx_data_reg;
            rx_valid_next  = 1'b0;
            aborted_next   = 1'b1;
        end
    end

    assign tx_ready_o = (state_reg == ST_IDLE);
    assign busy_o     = (state_reg != ST_IDLE);
    assign rx_valid_o = rx_valid_reg;
    assign rx_data_o  = rx_data_reg;
    assign aborted_o  = aborted_reg;
    assign spi_sclk_o = sclk_reg;
    assign spi_cs_o   = cs_reg;
    assign spi_mosi_o = mosi_reg;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Directed bench for spi_master: a default 32-bit instance and an 8-bit,
//   CLK_DIV=1 instance, both with MISO selectable between tie-0, tie-1 and
//   MOSI loopback.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n;

    // default instance
    logic        tx_valid, tx_ready, abort, rx_valid, aborted, busy;
    logic        sclk, cs, mosi, miso;
    logic [31:0] tx_data, rx_data;
    logic [1:0]  miso_mode;     // 0: tie 0, 1: tie 1, 2: loopback

    // 8-bit instance
    logic        tx_valid8, tx_ready8, abort8, rx_valid8, aborted8, busy8;
    logic        sclk8, cs8, mosi8;
    logic [7:0]  tx_data8, rx_data8;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    int rise8_cnt = 0;
    int rxv_cnt = 0;

    always #5 clk = ~clk;

    assign miso = (miso_mode == 2'd2) ? mosi : miso_mode[0];

    spi_master dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .tx_data_i  (tx_data),
        .abort_i    (abort),
        .rx_valid_o (rx_valid),
        .rx_data_o  (rx_data),
        .aborted_o  (aborted),
        .busy_o     (busy),
        .spi_sclk_o (sclk),
        .spi_cs_o   (cs),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso)
    );

    spi_master #(
        .FRAME_W (8),
        .CLK_DIV (1)
    ) dut8 (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .tx_valid_i (tx_valid8),
        .tx_ready_o (tx_ready8),
        .tx_data_i  (tx_data8),
        .abort_i    (abort8),
        .rx_valid_o (rx_valid8),
        .rx_data_o  (rx_data8),
        .aborted_o  (aborted8),
        .busy_o     (busy8),
        .spi_sclk_o (sclk8),
        .spi_cs_o   (cs8),
        .spi_mosi_o (mosi8),
        .spi_miso_i (mosi8)
    );

    always @(posedge sclk)  rise_cnt  <= rise_cnt + 1;
    always @(posedge sclk8) rise8_cnt <= rise8_cnt + 1;
    always @(posedge clk) if (rx_valid) rxv_cnt <= rxv_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Offers one word, drops tx_valid after the accept edge (and scrambles
    // tx_data to show it is ignored), then counts cycles until CS rises.
    // Returns at the negedge right after the CS rise edge.
    task automatic do_frame(input logic [31:0] data, output int cyc, output int rises);
        int r0;
        r0 = rise_cnt;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = data;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = ~data;
        cyc = 0;
        while (cs == 1'b0 && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        rises = rise_cnt - r0;
    endtask

    initial begin
        int cyc, rises, v0, r0, n, g;
        rst_n = 1'b0;
        tx_valid = 1'b0; tx_data = '0; abort = 1'b0; miso_mode = 2'd2;
        tx_valid8 = 1'b0; tx_data8 = '0; abort8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check("rst_cs",       cs, 1);
        check("rst_sclk",     sclk, 0);
        check("rst_mosi",     mosi, 0);
        check("rst_rx_data",  rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_aborted",  aborted, 0);
        check("rst_busy",     busy, 0);
        check("rst_tx_ready", tx_ready, 1);

        // loopback frame
        miso_mode = 2'd2;
        v0 = rxv_cnt;
        do_frame(32'hA5C3_0F81, cyc, rises);
        check("lb_cs_low",    cyc, 132);
        check("lb_rx_valid",  rx_valid, 1);
        check("lb_rx_data",   rx_data, 32'hA5C3_0F81);
        check("lb_rises",     rises, 32);
        check("lb_busy",      busy, 1);
        check("lb_tx_ready",  tx_ready, 0);
        repeat (5) @(negedge clk);
        check("lb_pulses",    rxv_cnt - v0, 1);
        check("lb_idle",      tx_ready, 1);

        // MISO tied high
        miso_mode = 2'd1;
        v0 = rxv_cnt;
        do_frame(32'h1357_9BDF, cyc, rises);
        check("one_rx_data",  rx_data, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        check("one_pulses",   rxv_cnt - v0, 1);

        // MISO tied low
        miso_mode = 2'd0;
        v0 = rxv_cnt;
        do_frame(32'hFFFF_FFFF, cyc, rises);
        check("zero_rx_data", rx_data, 32'h0000_0000);
        repeat (5) @(negedge clk);
        check("zero_pulses",  rxv_cnt - v0, 1);

        // back-to-back frames with tx_valid held
        miso_mode = 2'd2;
        v0 = rxv_cnt;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        tx_data = 32'hDEAD_BEEF;
        check("b2b_cs_low",   cs, 0);
        n = 0;
        while (cs == 1'b0 && n < 2000) begin @(negedge clk); n++; end
        check("b2b_rxv1",     rx_valid, 1);
        check("b2b_rx1",      rx_data, 32'h1234_5678);
        g = 0;
        while (cs == 1'b1 && g < 100) begin g++; @(negedge clk); end
        tx_valid = 1'b0;
        check("b2b_gap",      g, 2);
        n = 0;
        while (cs == 1'b0 && n < 2000) begin @(negedge clk); n++; end
        check("b2b_rxv2",     rx_valid, 1);
        check("b2b_rx2",      rx_data, 32'hDEAD_BEEF);
        repeat (5) @(negedge clk);
        check("b2b_pulses",   rxv_cnt - v0, 2);

        // abort after the 10th SCLK rise
        v0 = rxv_cnt;
        r0 = rise_cnt;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 32'h0F0F_F0F0;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while ((rise_cnt - r0) < 10 && n < 1000) begin @(negedge clk); n++; end
        check("ab_rises10",   rise_cnt - r0, 10);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("ab_sclk",      sclk, 0);
        check("ab_cs",        cs, 1);
        check("ab_pulse",     aborted, 1);
        check("ab_rx_valid",  rx_valid, 0);
        @(negedge clk);
        check("ab_pulse_end", aborted, 0);
        repeat (200) @(negedge clk);
        check("ab_no_rx",     rxv_cnt - v0, 0);
        check("ab_rx_kept",   rx_data, 32'hDEAD_BEEF);
        check("ab_rises_end", rise_cnt - r0, 10);
        check("ab_idle",      tx_ready, 1);

        // abort while idle is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_idle_pulse", aborted, 0);
        check("ab_idle_cs",    cs, 1);

        // asynchronous reset in the middle of SHIFT
        v0 = rxv_cnt;
        r0 = rise_cnt;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while ((rise_cnt - r0) < 5 && n < 1000) begin @(negedge clk); n++; end
        check("rs_sclk_hi",   sclk, 1);
        #1 rst_n = 1'b0;
        #1;
        check("rs_cs",        cs, 1);
        check("rs_sclk",      sclk, 0);
        check("rs_busy",      busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rs_tx_ready",  tx_ready, 1);
        check("rs_no_rx",     rxv_cnt - v0, 0);
        check("rs_rx_data",   rx_data, 0);

        // 8-bit, CLK_DIV=1 loopback
        r0 = rise8_cnt;
        @(negedge clk);
        tx_valid8 = 1'b1;
        tx_data8  = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        tx_valid8 = 1'b0;
        tx_data8  = 8'hFF;
        cyc = 0;
        while (cs8 == 1'b0 && cyc < 500) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("w8_cs_low",    cyc, 20);
        check("w8_rx_valid",  rx_valid8, 1);
        check("w8_rx_data",   rx_data8, 8'h3C);
        check("w8_rises",     rise8_cnt - r0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
